// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer/response encodings and default-slave state type.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic       sel_none,
    output logic       ds_hreadyout,
    output logic       ds_hresp
);
    ds_state_t state;
    logic start;
    assign start = HREADY && sel_none && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) begin
            state        <= DS_IDLE;
            ds_hreadyout <= 1'b1;
            ds_hresp     <= HRESP_OKAY;
        end else if (state == DS_ERR1) begin
            state        <= DS_ERR2;
            ds_hreadyout <= 1'b1;
            ds_hresp     <= HRESP_ERROR;
        end else if (start) begin
            state        <= DS_ERR1;
            ds_hreadyout <= 1'b0;
            ds_hresp     <= HRESP_ERROR;
        end else begin
            state        <= DS_IDLE;
            ds_hreadyout <= 1'b1;
            ds_hresp     <= HRESP_OKAY;
        end
endmodule

// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux: registers decoder selects per address phase and routes the data-phase slave response.
module ahb_slave_mux #(
    parameter int NSLV = 2,
    parameter int DW   = 32
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NSLV-1:0]    HSEL,
    input  logic [1:0]         HTRANS,
    input  logic [NSLV*DW-1:0] HRDATA_S,
    input  logic [NSLV-1:0]    HREADYOUT_S,
    input  logic [NSLV-1:0]    HRESP_S,
    output logic               HREADY,
    output logic [DW-1:0]      HRDATA,
    output logic               HRESP
);
    logic [NSLV:0] dsel, nsel;
    logic sel_none, ds_hreadyout, ds_hresp;
    logic [DW-1:0] rdata;
    logic ready, resp;
    assign sel_none = ~|HSEL;
    // isolate the lowest set select bit so multi-hot decodes resolve deterministically
    assign nsel = {sel_none, HSEL & (~HSEL + NSLV'(1))};
    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) dsel <= {1'b1, {NSLV{1'b0}}};
        else if (HREADY) dsel <= nsel;
    always_comb begin
        rdata = '0;
        ready = dsel[NSLV] & ds_hreadyout;
        resp  = dsel[NSLV] & ds_hresp;
        for (int i = 0; i < NSLV; i++) begin
            rdata = rdata | ({DW{dsel[i]}} & HRDATA_S[i*DW +: DW]);
            ready = ready | (dsel[i] & HREADYOUT_S[i]);
            resp  = resp | (dsel[i] & HRESP_S[i]);
        end
    end
    assign HRDATA = rdata;
    assign HREADY = ready;
    assign HRESP  = resp;
    ahb_default_slave u_ds (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HREADY       (HREADY),
        .HTRANS       (HTRANS),
        .sel_none     (sel_none),
        .ds_hreadyout (ds_hreadyout),
        .ds_hresp     (ds_hresp)
    );
endmodule
